pe_incha_sched: RTL and testbench

Scheduler that sequences a single-MAC, input-channel-serial PE over a frame of pixels. For each pixel it issues one MAC operation per cycle, with output channel as the outer loop and input channel as the inner loop. It drives weight addresses and accumulate first/last flags, so the PE emits one finished output channel per IN_CHANNEL cycles into the serial-in output-channel collector. It handles the pixel handshake with upstream, gates on downstream readiness, and drains the MAC pipeline before reporting completion.

---
 rtl/pe_incha_sched.sv | 120 ++++++++++++
 tb/tb_pe_incha_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_incha_sched.sv
// pe_incha_sched: sequences a single-MAC input-channel-serial PE, output channel outer loop, input channel inner loop.
module pe_incha_sched #(
    parameter int IN_CHANNEL  = 16,
    parameter int OUT_CHANNEL = 16,
    parameter int MAC_LATENCY = 3,
    parameter int PIX_WIDTH   = 16,
    localparam int ICW = IN_CHANNEL > 1 ? $clog2(IN_CHANNEL) : 1,
    localparam int OCW = OUT_CHANNEL > 1 ? $clog2(OUT_CHANNEL) : 1,
    localparam int AW  = IN_CHANNEL * OUT_CHANNEL > 1 ? $clog2(IN_CHANNEL * OUT_CHANNEL) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [PIX_WIDTH-1:0] i_num_pixels,
    input  logic                 i_pix_valid,
    output logic                 o_pix_ack,
    input  logic                 i_out_ready,
    output logic                 o_mac_valid,
    output logic                 o_acc_first,
    output logic                 o_acc_last,
    output logic [ICW-1:0]       o_ic,
    output logic [OCW-1:0]       o_oc,
    output logic [AW-1:0]        o_w_addr,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int DW = MAC_LATENCY > 1 ? $clog2(MAC_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic [PIX_WIDTH-1:0] num_pix;
    logic [PIX_WIDTH-1:0] pix_cnt;
    logic [DW-1:0]        dcnt;
    logic                 ic_wrap;
    logic                 op_final;
    logic [ICW-1:0]       ic_nxt;
    logic [OCW-1:0]       oc_nxt;

    always_comb begin
        ic_wrap  = o_ic == ICW'(IN_CHANNEL - 1);
        op_final = ic_wrap && o_oc == OCW'(OUT_CHANNEL - 1);
        ic_nxt   = ic_wrap ? '0 : o_ic + ICW'(1);
        oc_nxt   = ic_wrap ? o_oc + OCW'(1) : o_oc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            num_pix     <= '0;
            pix_cnt     <= '0;
            dcnt        <= '0;
            o_pix_ack   <= 1'b0;
            o_mac_valid <= 1'b0;
            o_acc_first <= 1'b0;
            o_acc_last  <= 1'b0;
            o_ic        <= '0;
            o_oc        <= '0;
            o_w_addr    <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_pix_ack   <= 1'b0;
            o_mac_valid <= 1'b0;
            o_acc_first <= 1'b0;
            o_acc_last  <= 1'b0;
            o_done      <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    num_pix <= i_num_pixels;
                    pix_cnt <= '0;
                    o_busy  <= 1'b1;
                    state   <= i_num_pixels == '0 ? DONE : WAIT;
                end
                WAIT: if (i_pix_valid && i_out_ready) begin
                    state       <= RUN;
                    o_mac_valid <= 1'b1;
                    o_ic        <= '0;
                    o_oc        <= '0;
                    o_w_addr    <= '0;
                    o_acc_first <= 1'b1;
                    o_acc_last  <= IN_CHANNEL == 1;
                    o_pix_ack   <= IN_CHANNEL * OUT_CHANNEL == 1;
                end
                RUN: if (op_final) begin
                    state <= DRAIN;
                    dcnt  <= '0;
                end else begin
                    o_mac_valid <= 1'b1;
                    o_ic        <= ic_nxt;
                    o_oc        <= oc_nxt;
                    o_w_addr    <= o_w_addr + AW'(1);
                    o_acc_first <= ic_wrap;
                    o_acc_last  <= ic_nxt == ICW'(IN_CHANNEL - 1);
                    o_pix_ack   <= ic_nxt == ICW'(IN_CHANNEL - 1) && oc_nxt == OCW'(OUT_CHANNEL - 1);
                end
                DRAIN: if (dcnt == DW'(MAC_LATENCY - 1)) begin
                    pix_cnt <= pix_cnt + PIX_WIDTH'(1);
                    if (pix_cnt + PIX_WIDTH'(1) == num_pix) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
                // an empty frame arrives here with o_done low and spends one extra cycle raising it
                DONE: begin
                    o_done <= ~o_done;
                    if (o_done) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_incha_sched.sv
// tb_pe_incha_sched: scoreboard bench for pe_incha_sched with IN=4, OUT=2, MAC_LATENCY=3.
module tb_pe_incha_sched;
    localparam int IC  = 4;
    localparam int OC  = 2;
    localparam int ML  = 3;
    localparam int PW  = 16;
    localparam int ICW = $clog2(IC);
    localparam int OCW = $clog2(OC);
    localparam int AW  = $clog2(IC * OC);
    localparam int PIX_CYC = 1 + IC * OC + ML;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic [PW-1:0]  i_num_pixels = '0;
    logic           i_pix_valid = 1'b0;
    logic           i_out_ready = 1'b0;
    logic           o_pix_ack, o_mac_valid, o_acc_first, o_acc_last, o_busy, o_done;
    logic [ICW-1:0] o_ic;
    logic [OCW-1:0] o_oc;
    logic [AW-1:0]  o_w_addr;
    logic [5+ICW+OCW+AW:0] outs;

    pe_incha_sched #(.IN_CHANNEL(IC), .OUT_CHANNEL(OC), .MAC_LATENCY(ML), .PIX_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_pixels(i_num_pixels),
        .i_pix_valid(i_pix_valid), .o_pix_ack(o_pix_ack), .i_out_ready(i_out_ready),
        .o_mac_valid(o_mac_valid), .o_acc_first(o_acc_first), .o_acc_last(o_acc_last),
        .o_ic(o_ic), .o_oc(o_oc), .o_w_addr(o_w_addr), .o_busy(o_busy), .o_done(o_done)
    );

    assign outs = {o_pix_ack, o_mac_valid, o_acc_first, o_acc_last, o_ic, o_oc, o_w_addr, o_busy, o_done};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [ICW-1:0] ic;
        logic [OCW-1:0] oc;
        logic           first;
        logic           last;
        logic           ack;
    } op_t;

    op_t exp_q[$];
    op_t got;
    int  checks = 0, failures = 0, cyc = 0;
    int  op_cnt = 0, ack_cnt = 0, done_cnt = 0;
    int  first_op_cyc = -1, ack_cyc = 0, done_cyc = 0, busy_fall_cyc = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // every pixel walks all output channels, each over all input channels
    function automatic void push_frame(input int n);
        op_t e;
        for (int p = 0; p < n; p++)
            for (int oc = 0; oc < OC; oc++)
                for (int ic = 0; ic < IC; ic++) begin
                    e.addr  = AW'(oc * IC + ic);
                    e.ic    = ICW'(ic);
                    e.oc    = OCW'(oc);
                    e.first = ic == 0;
                    e.last  = ic == IC - 1;
                    e.ack   = ic == IC - 1 && oc == OC - 1;
                    exp_q.push_back(e);
                end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (o_mac_valid) begin
                got = {o_w_addr, o_ic, o_oc, o_acc_first, o_acc_last, o_pix_ack};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL op_unexpected: got %0h expected no op", got);
                end else begin
                    chk("op", got, exp_q.pop_front());
                end
                op_cnt++;
                if (first_op_cyc < 0) first_op_cyc = cyc;
            end
            if (o_pix_ack) begin
                ack_cnt++;
                ack_cyc = cyc;
                chk("ack_with_op", o_mac_valid, 1);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_busy && !o_busy) busy_fall_cyc = cyc;
        end
        prev_busy = o_busy;
    end

    task automatic start_frame(input int n, output int s);
        @(posedge clk);
        #1;
        s = cyc;
        i_start = 1'b1;
        i_num_pixels = PW'(n);
        first_op_cyc = -1;
        push_frame(n);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // mode 0: quiet, 1: stray i_start pulses, 2: also random valid/ready
    task automatic wait_done(input int d0, input int mode);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > d0) ok = 1'b1;
            else if (mode > 0) begin
                i_start = $urandom_range(0, 7) == 0;
                i_num_pixels = PW'($urandom);
                if (mode == 2) begin
                    i_pix_valid = $urandom_range(0, 1) == 1;
                    i_out_ready = $urandom_range(0, 1) == 1;
                end
            end
        end
        i_start = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no o_done expected one within 3000 cycles");
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int s, a0, o0, d0, o1, n, mode;
        bit found;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_outputs", outs, 0);
        end

        i_pix_valid = 1'b1;
        i_out_ready = 1'b1;
        a0 = ack_cnt; o0 = op_cnt; d0 = done_cnt;
        start_frame(1, s);
        wait_done(d0, 0);
        chk("first_op_latency", first_op_cyc - s, 2);
        chk("ack_at_op7", ack_cyc - first_op_cyc, 7);
        chk("done_after_ack", done_cyc - ack_cyc, 4);
        chk("busy_fall", busy_fall_cyc - done_cyc, 1);
        chk("ops_1pix", op_cnt - o0, 8);
        chk("acks_1pix", ack_cnt - a0, 1);
        chk("dones_1pix", done_cnt - d0, 1);
        chk("queue_1pix", exp_q.size(), 0);

        a0 = ack_cnt; o0 = op_cnt; d0 = done_cnt;
        start_frame(3, s);
        for (int i = 0; i < 200 && ack_cnt == a0; i++) begin
            @(posedge clk);
            #1;
        end
        i_out_ready = 1'b0;
        o1 = op_cnt;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        chk("stall_no_ops", op_cnt, o1);
        chk("stall_busy", o_busy, 1);
        i_out_ready = 1'b1;
        wait_done(d0, 0);
        chk("acks_3pix", ack_cnt - a0, 3);
        chk("ops_3pix", op_cnt - o0, 24);
        chk("dones_3pix", done_cnt - d0, 1);
        chk("queue_3pix", exp_q.size(), 0);

        o0 = op_cnt; d0 = done_cnt;
        start_frame(0, s);
        wait_done(d0, 0);
        chk("zero_done_latency", done_cyc - s, 2);
        chk("zero_no_ops", op_cnt - o0, 0);
        chk("zero_dones", done_cnt - d0, 1);

        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 3);
            mode = $urandom_range(1, 2);
            i_pix_valid = 1'b1;
            i_out_ready = 1'b1;
            a0 = ack_cnt; o0 = op_cnt; d0 = done_cnt;
            start_frame(n, s);
            wait_done(d0, mode);
            chk("rand_acks", ack_cnt - a0, n);
            chk("rand_ops", op_cnt - o0, n * IC * OC);
            chk("rand_dones", done_cnt - d0, 1);
            chk("rand_queue", exp_q.size(), 0);
            if (mode == 1) chk("rand_frame_cycles", done_cyc - s, 1 + n * PIX_CYC);
        end

        i_pix_valid = 1'b1;
        i_out_ready = 1'b1;
        a0 = ack_cnt; d0 = done_cnt;
        start_frame(1, s);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            found = o_mac_valid && o_w_addr == AW'(5);
        end
        chk("reset_op5_seen", found, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_run", outs, 0);
        exp_q.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("reset_held", outs, 0);
        chk("reset_no_ack", ack_cnt - a0, 0);
        chk("reset_no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        a0 = ack_cnt; o0 = op_cnt; d0 = done_cnt;
        start_frame(1, s);
        wait_done(d0, 0);
        chk("restart_latency", first_op_cyc - s, 2);
        chk("restart_ops", op_cnt - o0, 8);
        chk("restart_dones", done_cnt - d0, 1);
        chk("restart_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
